// File: rtl/ni_injector_if.sv
// PE/router-facing signal bundle for the network interface injector.
// master = PE and router side, slave = the injector itself.
interface ni_injector_if;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [3:0]  pkt_dst_x;
    logic [3:0]  pkt_dst_y;
    logic [7:0]  pkt_len;
    logic [31:0] pe_data;
    logic        pe_data_valid;
    logic        pe_data_ready;
    logic        diff_pair_p;
    logic        diff_pair_n;
    logic [31:0] output_channel;
    logic        crt_in;
    logic [3:0]  credits;
    logic        busy;
    logic        credit_err;

    modport master (
        output pkt_valid, pkt_dst_x, pkt_dst_y, pkt_len, pe_data, pe_data_valid, crt_in,
        input  pkt_ready, pe_data_ready, diff_pair_p, diff_pair_n, output_channel,
               credits, busy, credit_err
    );

    modport slave (
        input  pkt_valid, pkt_dst_x, pkt_dst_y, pkt_len, pe_data, pe_data_valid, crt_in,
        output pkt_ready, pe_data_ready, diff_pair_p, diff_pair_n, output_channel,
               credits, busy, credit_err
    );
endinterface

// File: rtl/ni_injector.sv
// PE-side packet injector: header + body flits onto a credit-flow-controlled router port.
// Flits launch from the FSM and appear one cycle later on registered strobe/data outputs.
module ni_injector #(
    parameter int XCOR         = 2,
    parameter int YCOR         = 2,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    ni_injector_if.slave ni
);
    localparam logic [3:0] SRC_X = 4'(XCOR);
    localparam logic [3:0] SRC_Y = 4'(YCOR);
    localparam logic [3:0] DEPTH = 4'(BUFFER_DEPTH);

    typedef enum logic [1:0] {IDLE, HEADER, BODY} state_t;

    typedef struct packed {
        logic [3:0] dst_x;
        logic [3:0] dst_y;
        logic [7:0] len;
    } desc_t;

    state_t      state, state_nxt;
    desc_t       desc;
    logic [7:0]  remain, remain_nxt;
    logic [3:0]  credits;
    logic        have_credit;
    logic        launch;
    logic [31:0] flit;

    assign have_credit = (credits != 4'd0);
    assign ni.credits  = credits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            remain <= '0;
            desc   <= '0;
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
            if (state == IDLE && ni.pkt_valid)
                desc <= '{dst_x: ni.pkt_dst_x, dst_y: ni.pkt_dst_y, len: ni.pkt_len};
        end
    end

    always_comb begin
        state_nxt        = state;
        remain_nxt       = remain;
        launch           = 1'b0;
        flit             = '0;
        ni.pkt_ready     = 1'b0;
        ni.pe_data_ready = 1'b0;
        ni.busy          = (state != IDLE);
        unique case (state)
            IDLE: begin
                ni.pkt_ready = 1'b1;
                if (ni.pkt_valid) state_nxt = HEADER;
            end
            HEADER: begin
                if (have_credit) begin
                    launch = 1'b1;
                    flit   = {desc.dst_x, desc.dst_y, SRC_X, SRC_Y, desc.len, 8'h00};
                    if (desc.len == 8'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        remain_nxt = desc.len;
                        state_nxt  = BODY;
                    end
                end
            end
            BODY: begin
                ni.pe_data_ready = have_credit;
                if (have_credit && ni.pe_data_valid) begin
                    launch     = 1'b1;
                    flit       = ni.pe_data;
                    remain_nxt = remain - 8'd1;
                    if (remain == 8'd1) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A credit returned alongside a launch cancels out; a surplus credit at full depth is flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits       <= DEPTH;
            ni.credit_err <= 1'b0;
        end else if (ni.crt_in && !launch) begin
            if (credits == DEPTH) ni.credit_err <= 1'b1;
            else                  credits       <= credits + 4'd1;
        end else if (launch && !ni.crt_in) begin
            credits <= credits - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ni.diff_pair_p    <= 1'b0;
            ni.diff_pair_n    <= 1'b1;
            ni.output_channel <= '0;
        end else begin
            ni.diff_pair_p    <= launch;
            ni.diff_pair_n    <= ~launch;
            ni.output_channel <= launch ? flit : 32'h0;
        end
    end
endmodule
